// File: rtl/clock_pkg.sv
// Shared field limits, widths, edit-state encoding and field stepping helpers
// for the alarm-time writer.
package clock_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [4:0] HOUR_MAX = 5'd23;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] SEC_MAX  = 6'd59;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EDIT_HOUR = 2'd1,
        EDIT_MIN  = 2'd2,
        EDIT_SEC  = 2'd3
    } edit_state_e;

    function automatic int ring_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    // Modulo step of one time field; out-of-range values fall back onto the legal range.
    function automatic logic [5:0] step_field(input logic [5:0] value,
                                              input logic [5:0] max_value,
                                              input logic       up);
        logic [5:0] result;
        if (up) begin
            if (value >= max_value) result = 6'd0;
            else                    result = value + 6'd1;
        end else begin
            if ((value == 6'd0) || (value > max_value)) result = max_value;
            else                                        result = value - 6'd1;
        end
        return result;
    endfunction

    function automatic edit_state_e next_state(input edit_state_e state);
        edit_state_e result;
        case (state)
            IDLE:      result = EDIT_HOUR;
            EDIT_HOUR: result = EDIT_MIN;
            EDIT_MIN:  result = EDIT_SEC;
            EDIT_SEC:  result = IDLE;
            default:   result = IDLE;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/alarm_setter_btn_edge.sv
// Press detector for one debounced button: a press is a high level whose
// previous sampled level was low, so holding yields a single pulse.
module btn_edge (
    input  logic signal,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic hist_r;

    // Button level history, one cycle deep.
    always_ff @(posedge signal) begin
        if (reset) begin
            hist_r <= 1'b0;
        end else begin
            hist_r <= btn;
        end
    end

    assign press = btn & ~hist_r;

endmodule

// File: rtl/alarm_setter.sv
// Alarm-time writer: button edit FSM, alarm compare and timed ring output.
// Optional hold-to-repeat stepping is enabled by defining ALARM_AUTO_REPEAT_EN.
module alarm_setter
    import clock_pkg::*;
#(
    parameter int RING_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 250
) (
    input  logic       signal,
    input  logic       reset,
    input  logic       alarm_on,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [4:0] hour_true,
    input  logic [5:0] minute_true,
    input  logic [5:0] second_true,
    output logic [4:0] hour_al,
    output logic [5:0] minute_al,
    output logic [5:0] second_al,
    output logic [1:0] edit_field,
    output logic       ring
);

    localparam int RING_W = ring_cnt_width(RING_CYCLES);
    localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_CYCLES);

    edit_state_e       state_r;
    logic [4:0]        hour_al_r;
    logic [5:0]        minute_al_r;
    logic [5:0]        second_al_r;
    logic [RING_W-1:0] ring_cnt_r;
    logic              ring_r;
    logic              match_prev_r;

    logic              mode_p_s;
    logic              inc_p_s;
    logic              dec_p_s;
    logic              rep_inc_s;
    logic              rep_dec_s;
    logic              inc_step_s;
    logic              dec_step_s;
    logic              edit_s;
    logic              match_s;
    logic              ring_clr_s;
    logic [RING_W-1:0] ring_cnt_s;

    btn_edge u_mode (.signal(signal), .reset(reset), .btn(btn_mode), .press(mode_p_s));
    btn_edge u_inc  (.signal(signal), .reset(reset), .btn(btn_inc),  .press(inc_p_s));
    btn_edge u_dec  (.signal(signal), .reset(reset), .btn(btn_dec),  .press(dec_p_s));

`ifdef ALARM_AUTO_REPEAT_EN
    localparam int HOLD_W = $clog2(REPEAT_CYCLES + 1);

    logic [HOLD_W-1:0] hold_cnt_r;
    logic              held_s;
    logic              rep_s;

    // A repeat step fires every REPEAT_CYCLES edges while exactly one of inc/dec stays high.
    always_comb begin
        held_s    = (state_r != IDLE) && (btn_inc ^ btn_dec) && !mode_p_s;
        rep_s     = held_s && (hold_cnt_r == HOLD_W'(REPEAT_CYCLES));
        rep_inc_s = rep_s & btn_inc;
        rep_dec_s = rep_s & btn_dec;
    end

    // Hold counter; restarting at one keeps the repeat period equal to the first delay.
    always_ff @(posedge signal) begin
        if (reset) begin
            hold_cnt_r <= {HOLD_W{1'b0}};
        end else if (!held_s) begin
            hold_cnt_r <= {HOLD_W{1'b0}};
        end else if (rep_s) begin
            hold_cnt_r <= HOLD_W'(1);
        end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
        end
    end
`else
    // Without auto-repeat a held button gives exactly one step.
    always_comb begin
        rep_inc_s = 1'b0;
        rep_dec_s = 1'b0;
    end
`endif

    // Step requests, alarm match and the next ring counter value.
    always_comb begin
        inc_step_s = inc_p_s | rep_inc_s;
        dec_step_s = dec_p_s | rep_dec_s;
        edit_s     = (state_r != IDLE) && !mode_p_s && (inc_step_s ^ dec_step_s);
        match_s    = (state_r == IDLE) && alarm_on &&
                     (hour_true == hour_al_r) && (minute_true == minute_al_r) &&
                     (second_true == second_al_r);
        // Leaving IDLE always coincides with a mode press, so it is covered here.
        ring_clr_s = mode_p_s | inc_p_s | dec_p_s | ~alarm_on;
        ring_cnt_s = ring_cnt_r;
        if (ring_clr_s) begin
            ring_cnt_s = {RING_W{1'b0}};
        end else if (match_s && !match_prev_r) begin
            ring_cnt_s = RING_LOAD;
        end else if (ring_cnt_r != {RING_W{1'b0}}) begin
            ring_cnt_s = ring_cnt_r - RING_W'(1);
        end else begin
            ring_cnt_s = ring_cnt_r;
        end
    end

    // Edit FSM, alarm fields and registered ring state.
    always_ff @(posedge signal) begin
        if (reset) begin
            state_r      <= IDLE;
            hour_al_r    <= 5'd0;
            minute_al_r  <= 6'd0;
            second_al_r  <= 6'd0;
            ring_cnt_r   <= {RING_W{1'b0}};
            ring_r       <= 1'b0;
            match_prev_r <= 1'b0;
        end else begin
            if (mode_p_s) begin
                state_r <= next_state(state_r);
            end
            if (edit_s) begin
                case (state_r)
                    EDIT_HOUR: hour_al_r   <= 5'(step_field({1'b0, hour_al_r}, {1'b0, HOUR_MAX}, inc_step_s));
                    EDIT_MIN:  minute_al_r <= step_field(minute_al_r, MIN_MAX, inc_step_s);
                    EDIT_SEC:  second_al_r <= step_field(second_al_r, SEC_MAX, inc_step_s);
                    default:   hour_al_r   <= hour_al_r;
                endcase
            end
            match_prev_r <= match_s;
            ring_cnt_r   <= ring_cnt_s;
            ring_r       <= (ring_cnt_s != {RING_W{1'b0}});
        end
    end

    assign hour_al    = hour_al_r;
    assign minute_al  = minute_al_r;
    assign second_al  = second_al_r;
    assign edit_field = state_r;
    assign ring       = ring_r;

endmodule

// File: tb/tb_alarm_setter.sv
// Self-checking bench for alarm_setter: a behavioural model pushes expected
// outputs per driven edge; they are popped and compared after the edge.
module tb_alarm_setter;

    localparam int RING = 8;
    localparam int REP  = 4;

    logic       signal = 1'b0;
    logic       reset = 1'b1;
    logic       alarm_on = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic [4:0] hour_true = 5'd0;
    logic [5:0] minute_true = 6'd0;
    logic [5:0] second_true = 6'd0;
    logic [4:0] hour_al;
    logic [5:0] minute_al;
    logic [5:0] second_al;
    logic [1:0] edit_field;
    logic       ring;

    alarm_setter #(.RING_CYCLES(RING), .REPEAT_CYCLES(REP)) dut (
        .signal(signal), .reset(reset), .alarm_on(alarm_on),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .hour_true(hour_true), .minute_true(minute_true), .second_true(second_true),
        .hour_al(hour_al), .minute_al(minute_al), .second_al(second_al),
        .edit_field(edit_field), .ring(ring)
    );

    always #5 signal = ~signal;

    typedef struct {
        string       tag;
        logic [19:0] val;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    int  m_field, m_h, m_m, m_s, m_rc, m_hc;
    bit  m_mprev, m_lm, m_li, m_ld;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] model_word();
        return {2'(m_field), 5'(m_h), 6'(m_m), 6'(m_s), (m_rc != 0)};
    endfunction

    task automatic compare_next();
        sb_t e;
        if (sb_q.size() == 0) begin
            check_val("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_val(e.tag, {edit_field, hour_al, minute_al, second_al, ring}, e.val);
        end
    endtask

    task automatic do_reset(input string tag);
        sb_t e;
        reset = 1'b1;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        m_field = 0; m_h = 0; m_m = 0; m_s = 0; m_rc = 0; m_hc = 0;
        m_mprev = 1'b0; m_lm = 1'b0; m_li = 1'b0; m_ld = 1'b0;
        e.tag = tag; e.val = 20'd0;
        sb_q.push_back(e);
        @(posedge signal); #1;
        reset = 1'b0;
        compare_next();
    endtask

    // Drive button levels for one edge, predict the outputs, then compare.
    task automatic tick(input logic bm, input logic bi, input logic bd, input string tag);
        bit  pm, pi, pd, match, up, dn;
        int  delta;
        sb_t e;
        btn_mode = bm; btn_inc = bi; btn_dec = bd;
        pm = bm && !m_lm; pi = bi && !m_li; pd = bd && !m_ld;
        m_lm = bm; m_li = bi; m_ld = bd;
        match = (m_field == 0) && alarm_on && (int'(hour_true) == m_h) &&
                (int'(minute_true) == m_m) && (int'(second_true) == m_s);
        if (pm || pi || pd || !alarm_on) m_rc = 0;
        else if (match && !m_mprev)      m_rc = RING;
        else if (m_rc > 0)               m_rc = m_rc - 1;
        m_mprev = match;
        up = pi; dn = pd;
`ifdef ALARM_AUTO_REPEAT_EN
        if ((m_field != 0) && (bi != bd) && !pm) begin
            if (m_hc == REP) begin
                up = up | bi; dn = dn | bd; m_hc = 1;
            end else begin
                m_hc = m_hc + 1;
            end
        end else begin
            m_hc = 0;
        end
`endif
        if (pm) begin
            m_field = (m_field + 1) % 4;
        end else if ((m_field != 0) && (up != dn)) begin
            delta = up ? 1 : -1;
            if (m_field == 1) m_h = (m_h + 24 + delta) % 24;
            if (m_field == 2) m_m = (m_m + 60 + delta) % 60;
            if (m_field == 3) m_s = (m_s + 60 + delta) % 60;
        end
        e.tag = tag; e.val = model_word();
        sb_q.push_back(e);
        @(posedge signal); #1;
        compare_next();
    endtask

    task automatic press(input logic bm, input logic bi, input logic bd, input string tag);
        tick(bm, bi, bd, tag);
        tick(1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hour_true = 5'(h); minute_true = 6'(m); second_true = 6'(s);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int saved;
        int exp_tab[4];

        do_reset("reset");

        // Mode walks through all edit fields and back to idle.
        press(1'b1, 1'b0, 1'b0, "mode1"); check_val("field_hour", 32'(edit_field), 32'd1);
        press(1'b1, 1'b0, 1'b0, "mode2"); check_val("field_min", 32'(edit_field), 32'd2);
        press(1'b1, 1'b0, 1'b0, "mode3"); check_val("field_sec", 32'(edit_field), 32'd3);
        press(1'b1, 1'b0, 1'b0, "mode4"); check_val("field_idle", 32'(edit_field), 32'd0);
        press(1'b0, 1'b1, 1'b0, "idle_inc"); check_val("idle_inc_hour", 32'(hour_al), 32'd0);

        // Hour wrap in both directions, then minute wrap.
        press(1'b1, 1'b0, 1'b0, "to_hour");
        press(1'b0, 1'b0, 1'b1, "hour_dec"); check_val("hour_wrap_dec", 32'(hour_al), 32'd23);
        press(1'b0, 1'b1, 1'b0, "hour_inc"); check_val("hour_wrap_inc", 32'(hour_al), 32'd0);
        press(1'b0, 1'b0, 1'b1, "hour_dec2");
        press(1'b1, 1'b0, 1'b0, "to_min");
        press(1'b0, 1'b0, 1'b1, "min_dec"); check_val("min_wrap_dec", 32'(minute_al), 32'd59);
        press(1'b0, 1'b1, 1'b0, "min_inc"); check_val("min_wrap_inc", 32'(minute_al), 32'd0);
        check_val("hour_kept", 32'(hour_al), 32'd23);

`ifndef ALARM_AUTO_REPEAT_EN
        for (int k = 0; k < 50; k++) tick(1'b0, 1'b1, 1'b0, "hold_inc");
        check_val("hold_single_step", 32'(minute_al), 32'd1);
        tick(1'b0, 1'b0, 1'b0, "hold_release");
`endif

        saved = m_m;
        press(1'b0, 1'b1, 1'b1, "inc_dec"); check_val("inc_dec_same", 32'(minute_al), 32'(saved));
        press(1'b1, 1'b1, 1'b0, "mode_inc");
        check_val("mode_inc_field", 32'(edit_field), 32'd3);
        check_val("mode_inc_value", 32'(minute_al), 32'(saved));

        // Program 07:30:15 and return to idle.
        do_reset("reset2");
        press(1'b1, 1'b0, 1'b0, "set_h");
        repeat (7) press(1'b0, 1'b1, 1'b0, "set_h_inc");
        press(1'b1, 1'b0, 1'b0, "set_m");
        repeat (30) press(1'b0, 1'b0, 1'b1, "set_m_dec");
        press(1'b1, 1'b0, 1'b0, "set_s");
        repeat (15) press(1'b0, 1'b1, 1'b0, "set_s_inc");
        press(1'b1, 1'b0, 1'b0, "set_idle");
        check_val("alarm_value", {hour_al, minute_al, second_al}, {5'd7, 6'd30, 6'd15});

        // Matching second produces exactly RING cycles of ring.
        alarm_on = 1'b1;
        set_time(7, 30, 14); tick(1'b0, 1'b0, 1'b0, "pre_match");
        set_time(7, 30, 15); tick(1'b0, 1'b0, 1'b0, "match");
        check_val("ring_start", 32'(ring), 32'd1);
        cnt = 1;
        for (int k = 0; k < 2 * RING; k++) begin
            tick(1'b0, 1'b0, 1'b0, "ring_run");
            if (ring) cnt++;
        end
        check_val("ring_len", 32'(cnt), 32'(RING));

        // No ring while alarm_on is low.
        alarm_on = 1'b0;
        set_time(7, 30, 14); tick(1'b0, 1'b0, 1'b0, "off_pre");
        set_time(7, 30, 15);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0, 1'b0, "off_match");
            check_val("ring_off", 32'(ring), 32'd0);
        end
        set_time(7, 30, 14); tick(1'b0, 1'b0, 1'b0, "off_post");

        // A button press silences the ring with no retrigger in the same second.
        alarm_on = 1'b1;
        tick(1'b0, 1'b0, 1'b0, "clr_pre");
        set_time(7, 30, 15); tick(1'b0, 1'b0, 1'b0, "clr_match");
        check_val("clr_ring_on", 32'(ring), 32'd1);
        tick(1'b0, 1'b0, 1'b0, "clr_run");
        tick(1'b0, 1'b1, 1'b0, "clr_press");
        check_val("clr_ring_off", 32'(ring), 32'd0);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b0, 1'b0, "clr_hold");
            if (ring) cnt++;
        end
        check_val("no_retrigger", 32'(cnt), 32'd0);

        // Reset mid-ring.
        set_time(7, 30, 14); tick(1'b0, 1'b0, 1'b0, "rr_pre");
        set_time(7, 30, 15); tick(1'b0, 1'b0, 1'b0, "rr_match");
        check_val("rr_ring_on", 32'(ring), 32'd1);
        do_reset("reset_mid_ring");

`ifdef ALARM_AUTO_REPEAT_EN
        // Hold inc in EDIT_SEC from 58: steps at 0, REP, 2*REP, 3*REP.
        alarm_on = 1'b0;
        exp_tab[0] = 59; exp_tab[1] = 0; exp_tab[2] = 1; exp_tab[3] = 2;
        repeat (3) press(1'b1, 1'b0, 1'b0, "rep_to_sec");
        repeat (2) press(1'b0, 1'b0, 1'b1, "rep_dec");
        check_val("rep_start", 32'(second_al), 32'd58);
        for (int k = 0; k < 13; k++) begin
            tick(1'b0, 1'b1, 1'b0, "rep_hold");
            if (k % REP == 0) check_val("auto_repeat", 32'(second_al), 32'(exp_tab[k / REP]));
        end
        tick(1'b0, 1'b0, 1'b0, "rep_release");
`else
        exp_tab[0] = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
